// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S receiver.
// The bit clock, word select and serial data are synchronised into clk. Bits are
// captured MSB first on each bit-clock rise. A left+right slot pair is presented
// as parallel words together with a one-cycle frame_valid strobe.
//
// Output protocol: frame_valid and short_err are single-cycle strobes with no
// backpressure. left_out/right_out change only in the cycle where a slot closes,
// and frame_valid is high in the same cycle that the paired right word appears.
module i2s_receiver #(
  parameter int NUM_BITS    = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_clk_in,
  input  logic                word_select_in,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] left_out,
  output logic [NUM_BITS-1:0] right_out,
  output logic                frame_valid,
  output logic                locked,
  output logic                short_err,
  output logic                dbg_state_o
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_q, ws_sync_q, sd_sync_q;
  logic                   sclk_d_q;
  logic                   sclk_s, ws_s, sd_s, rise;

  // Framing state
  state_t                 state_q, state_d;
  logic [NUM_BITS-1:0]    shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   have_left_q, have_left_d;
  logic                   ws_d_q, ws_d_d;
  logic [TW-1:0]          timeout_q, timeout_d;

  // Output registers
  logic [NUM_BITS-1:0]    left_q, left_d, right_q, right_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   locked_q, locked_d;
  logic                   short_err_q, short_err_d;

  // Combinational scratch for the slot-end word assembly
  logic [NUM_BITS-1:0]    shift_v, word_v;
  logic [CW-1:0]          cnt_v, shamt_v;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ws_s   = ws_sync_q[SYNC_STAGES-1];
  assign sd_s   = sd_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_d_q;

  assign left_out    = left_q;
  assign right_out   = right_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign short_err   = short_err_q;
  assign dbg_state_o = state_q;

  // Bring the three asynchronous I2S lines into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_d_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk_in};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], word_select_in};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], serial_in};
      sclk_d_q    <= sclk_s;
    end
  end

  // Next-state logic: alignment FSM, bit capture, slot close and watchdog
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    have_left_d   = have_left_q;
    ws_d_d        = ws_d_q;
    timeout_d     = timeout_q;
    left_d        = left_q;
    right_d       = right_q;
    locked_d      = locked_q;
    frame_valid_d = 1'b0;
    short_err_d   = 1'b0;
    shift_v       = shift_q;
    cnt_v         = bit_cnt_q;
    word_v        = '0;
    shamt_v       = '0;

    // Watchdog: a rise restarts it; otherwise count up and saturate at expiry.
    if (rise) begin
      ws_d_d    = ws_s;
      timeout_d = '0;
    end else if (timeout_q != TW'(TIMEOUT)) begin
      timeout_d = timeout_q + TW'(1);
      if (timeout_q == TW'(TIMEOUT - 1)) begin
        locked_d    = 1'b0;
        state_d     = ST_ALIGN;
        have_left_d = 1'b0;
        bit_cnt_d   = '0;
        shift_d     = '0;
      end
    end

    case (state_q)
      ST_ALIGN: begin
        // The WS-change edge only establishes alignment; its bit is dropped.
        if (rise && (ws_s != ws_d_q)) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = ST_RUN;
          locked_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (rise) begin
          // Bits beyond NUM_BITS in a long slot are ignored.
          if (bit_cnt_q < CW'(NUM_BITS)) begin
            shift_v = {shift_q[NUM_BITS-2:0], sd_s};
            cnt_v   = bit_cnt_q + CW'(1);
          end
          shift_d   = shift_v;
          bit_cnt_d = cnt_v;
          // The WS-change rise carries the final bit of the closing slot.
          if (ws_s != ws_d_q) begin
            shamt_v     = CW'(NUM_BITS) - cnt_v;
            word_v      = shift_v << shamt_v;
            short_err_d = (cnt_v < CW'(NUM_BITS));
            if (!ws_d_q) begin
              left_d      = word_v;
              have_left_d = 1'b1;
            end else begin
              right_d = word_v;
              if (have_left_q) begin
                frame_valid_d = 1'b1;
                have_left_d   = 1'b0;
              end
            end
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ALIGN;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      have_left_q   <= 1'b0;
      ws_d_q        <= 1'b0;
      timeout_q     <= '0;
      left_q        <= '0;
      right_q       <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      short_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      have_left_q   <= have_left_d;
      ws_d_q        <= ws_d_d;
      timeout_q     <= timeout_d;
      left_q        <= left_d;
      right_q       <= right_d;
      frame_valid_q <= frame_valid_d;
      locked_q      <= locked_d;
      short_err_q   <= short_err_d;
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: randomized and directed I2S streams against a bit-level model.
module tb_i2s_receiver;

  localparam int NB   = 24;
  localparam int SS   = 2;
  localparam int TO   = 1024;
  localparam int HALF = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_clk_in = 1'b0;
  logic ws_in = 1'b0;
  logic sd_in = 1'b0;
  logic [NB-1:0] left_out, right_out;
  logic frame_valid, locked, short_err, dbg_state;

  always #5 clk = ~clk;

  i2s_receiver #(.NUM_BITS(NB), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_clk_in(s_clk_in), .word_select_in(ws_in),
    .serial_in(sd_in), .left_out(left_out), .right_out(right_out),
    .frame_valid(frame_valid), .locked(locked), .short_err(short_err),
    .dbg_state_o(dbg_state)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [2*NB-1:0] exp_q[$];

  // Reference model state: slots as bit lists
  bit            m_locked = 0;
  bit            m_prev = 0;
  bit            m_bits[$];
  bit            m_have_left = 0;
  logic [NB-1:0] m_left = '0;
  logic [NB-1:0] m_right = '0;
  int            m_short = 0;
  int            seen_short = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_rise(input bit ws, input bit sd);
    logic [NB-1:0] word;
    if (!m_locked) begin
      if (ws != m_prev) begin
        m_locked = 1;
        m_bits.delete();
      end
    end else begin
      if (m_bits.size() < NB) m_bits.push_back(sd);
      if (ws != m_prev) begin
        word = '0;
        foreach (m_bits[i]) word[NB-1-i] = m_bits[i];
        if (m_bits.size() < NB) m_short++;
        if (!m_prev) begin
          m_left = word;
          m_have_left = 1;
        end else begin
          m_right = word;
          if (m_have_left) begin
            exp_q.push_back({m_left, m_right});
            m_have_left = 0;
          end
        end
        m_bits.delete();
      end
    end
    m_prev = ws;
  endtask

  task automatic model_timeout();
    m_locked = 0;
    m_have_left = 0;
    m_bits.delete();
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_prev = 0;
    m_have_left = 0;
    m_bits.delete();
    m_left = '0;
    m_right = '0;
  endtask

  // Driver tasks
  task automatic send_bit(input bit ws, input bit sd);
    @(negedge clk);
    s_clk_in = 1'b0;
    ws_in = ws;
    sd_in = sd;
    repeat (HALF - 1) @(negedge clk);
    s_clk_in = 1'b1;
    model_rise(ws, sd);
    repeat (HALF) @(negedge clk);
  endtask

  // data is left-justified; WS toggles on the last bit of the slot
  task automatic send_slot(input bit lvl, input logic [31:0] data, input int len);
    bit b;
    for (int k = 0; k < len; k++) begin
      b = (k < 32) ? data[31-k] : 1'b0;
      send_bit((k == len - 1) ? ~lvl : lvl, b);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int len);
    send_slot(1'b0, l, len);
    send_slot(1'b1, r, len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_clk_in = 1'b0;
    repeat (HALF) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    check("rst_locked", locked, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_short", short_err, 0);
  endtask

  task automatic end_phase(input string name);
    repeat (10) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_short_cnt"}, seen_short, m_short);
    check({name, "_locked"}, locked, m_locked);
    check({name, "_left"}, left_out, m_left);
    check({name, "_right"}, right_out, m_right);
  endtask

  // Monitor: pop and compare on every frame_valid
  logic [2*NB-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_valid: got left %0h right %0h expected no frame",
                   left_out, right_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_left", left_out, mon_e[2*NB-1:NB]);
          check("frame_right", right_out, mon_e[NB-1:0]);
        end
      end
      if (short_err) seen_short++;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [23:0] base, lv, rv;
    int len, short0;

    // Reset state
    repeat (3) @(negedge clk);
    check("init_left", left_out, 0);
    check("init_right", right_out, 0);
    check("init_locked", locked, 0);
    check("init_fv", frame_valid, 0);
    check("init_short", short_err, 0);
    rst = 1'b0;

    // 1: 32-bit slots with fixed patterns
    send_slot(1'b0, {24'hA5A5A5, 8'h00}, 32);
    repeat (4) @(negedge clk);
    check("t1_locked_after_ws", locked, 1);
    send_slot(1'b1, {24'h5A5A5A, 8'h00}, 32);
    for (int f = 0; f < 3; f++) send_frame({24'hA5A5A5, 8'h00}, {24'h5A5A5A, 8'h00}, 32);
    end_phase("t1");
    check("t1_left_value", left_out, 24'hA5A5A5);
    check("t1_right_value", right_out, 24'h5A5A5A);

    // 2: incrementing samples in 32-bit slots, then random data and slot lengths
    base = 24'($urandom);
    for (int f = 0; f < 20; f++) begin
      lv = base + 24'(2 * f);
      rv = base + 24'(2 * f + 1);
      send_frame({lv, 8'h00}, {rv, 8'h00}, 32);
    end
    end_phase("t2a");
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(40, 18);
      send_frame($urandom, $urandom, len);
    end
    end_phase("t2b");

    // 3: 16-bit slots
    short0 = seen_short;
    for (int f = 0; f < 3; f++) send_frame({16'hBEEF, 16'h0}, {16'h1234, 16'h0}, 16);
    end_phase("t3");
    check("t3_left_value", left_out, 24'hBEEF00);
    check("t3_right_value", right_out, 24'h123400);
    check("t3_short_pulses", seen_short - short0, 6);

    // 4: bit clock stalls mid-slot
    send_frame($urandom, $urandom, 32);
    for (int k = 0; k < 9; k++) send_bit(1'b0, 1'($urandom));
    check("t4_locked_before", locked, 1);
    @(negedge clk);
    s_clk_in = 1'b0;
    ws_in = 1'b0;
    sd_in = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    s_clk_in = 1'b1;
    model_rise(1'b0, 1'b1);
    repeat (TO + SS + 2) @(negedge clk);
    model_timeout();
    check("t4_locked_dropped", locked, 0);
    check("t4_left_hold", left_out, m_left);
    check("t4_right_hold", right_out, m_right);
    repeat (6) @(negedge clk);
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 32);
    for (int f = 0; f < 2; f++) send_frame($urandom, $urandom, 32);
    end_phase("t4");

    // 5: reset pulse inside a left slot
    send_frame($urandom, $urandom, 32);
    for (int k = 0; k < 8; k++) send_bit(1'b0, 1'($urandom));
    do_reset();
    send_slot(1'b0, $urandom, 24);
    send_slot(1'b1, $urandom, 32);
    check("t5_no_pair_yet", exp_q.size(), 0);
    for (int f = 0; f < 2; f++) send_frame($urandom, $urandom, 32);
    end_phase("t5");

    // 6: stream begins in a right slot
    do_reset();
    send_slot(1'b1, $urandom, 32);
    repeat (4) @(negedge clk);
    check("t6_right_updated", right_out, m_right);
    for (int f = 0; f < 2; f++) send_frame($urandom, $urandom, 32);
    end_phase("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
